// File: rtl/uart_tx_ctrl.sv
// ==== uart_tx_ctrl : UART transmit control (host handshake, baud timing, frame sequencing) ====
// ==== rev 1.0                                                                             ====
`default_nettype none

module uart_tx_ctrl #(
  parameter int WORD_SIZE    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int DIV_WIDTH    = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst_b,
  input  logic tx_valid,
  output logic tx_ready,
  output logic tx_busy,
  output logic tx_done,
  input  logic bit_count_lt,
  output logic load_data_reg,
  output logic load_shift_reg,
  output logic start,
  output logic clear,
  output logic shift
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam logic [DIV_WIDTH-1:0] TICK_CNT = DIV_WIDTH'(CLKS_PER_BIT - 1);

  state_t               state;
  logic                 hold_full;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 accept;
  logic                 tick;
  logic                 frame_end;

  generate
    if (CLKS_PER_BIT < 2 || WORD_SIZE < 1) begin : g_bad_params
      $error("uart_tx_ctrl: CLKS_PER_BIT must be >= 2 and WORD_SIZE >= 1");
    end
  endgenerate

  assign accept    = tx_valid && !hold_full;
  assign tick      = (state == SEND) && (div_cnt == TICK_CNT);
  assign frame_end = tick && !bit_count_lt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= IDLE;
      hold_full <= 1'b0;
      div_cnt   <= '0;
    end else begin
      // LOAD always consumes the held byte; an accept cannot occur then since hold_full is set
      if (state == LOAD) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (hold_full) state <= LOAD;
        end
        LOAD: begin
          state   <= SEND;
          div_cnt <= '0;
        end
        SEND: begin
          div_cnt <= tick ? '0 : div_cnt + DIV_WIDTH'(1);
          // hold_full is the pre-accept value: a byte taken on the done cycle goes via IDLE
          if (frame_end) state <= hold_full ? LOAD : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx_ready       = !hold_full;
  assign tx_busy        = (state != IDLE);
  assign tx_done        = frame_end;
  assign load_data_reg  = accept;
  assign load_shift_reg = (state == LOAD);
  assign start          = (state == LOAD);
  assign clear          = (state == LOAD);
  assign shift          = tick && bit_count_lt;

endmodule

`default_nettype wire

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Control unit for the UART transmit path. It accepts bytes from the host over a valid/ready handshake and generates the baud-rate timing. It also sequences the transmit datapath (holding register, 9-bit shift register, bit counter) through one complete frame per byte. The datapath holding register is used as a one-deep buffer, so the host can queue the next byte while the current frame is shifting, and frames go out back-to-back.

## Interface
Parameters:
- WORD_SIZE, 8, data bits per frame; must match the datapath.
- CLKS_PER_BIT, 16, clk cycles per bit period; legal range ≥ 2.
- DIV_WIDTH, $clog2(CLKS_PER_BIT), width of the baud divider counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- tx_valid  in  1  host presents a byte (the byte itself goes straight to the datapath data bus).
- tx_ready  out  1  holding register empty; a byte is accepted when tx_valid && tx_ready.
- tx_busy  out  1  frame in progress (state ≠ IDLE).
- tx_done  out  1  one-cycle pulse at the end of each frame.
- bit_count_lt  in  1  datapath flag; high while the bit counter is below WORD_SIZE+1.
- load_data_reg  out  1  capture the data bus into the holding register.
- load_shift_reg  out  1  load the shift register with {holding reg, 1}.
- start  out  1  force shift register bit 0 to 0 (start bit).
- clear  out  1  zero the datapath bit counter.
- shift  out  1  shift right one bit, fill with 1, and increment the bit counter.

## Operation
- State: FSM {IDLE, LOAD, SEND}, hold_full flag, and baud counter div_cnt[DIV_WIDTH-1:0].
- Output decoding:
  - All datapath strobes and tx_done are combinational decodes of the state registers and inputs. There are no registered outputs.
  - tx_ready = !hold_full.
- Accept:
  - load_data_reg = tx_valid && !hold_full.
  - On accept, hold_full goes to 1 on the next edge.
  - When hold_full=1, tx_valid is ignored and there is no overwrite.
- IDLE:
  - All strobes are 0.
  - If hold_full=1, go to LOAD.
- LOAD (exactly 1 cycle):
  - load_shift_reg=1, start=1, clear=1.
  - hold_full goes to 0 and div_cnt goes to 0.
  - Next state is SEND.
- SEND:
  - div_cnt increments every cycle. tick = (div_cnt == CLKS_PER_BIT-1), and div_cnt wraps to 0 on tick.
  - On a tick with bit_count_lt=1: shift=1 for that cycle only.
  - On a tick with bit_count_lt=0: tx_done=1 for that cycle, and no shift.
    - Next state is LOAD if hold_full=1 (including a byte accepted earlier in the frame).
    - Otherwise next state is IDLE.
- A byte can be accepted in any state while hold_full=0, including the tx_done cycle. On the tx_done cycle, hold_full is sampled before the accept, so a byte accepted in that cycle goes IDLE→LOAD one cycle later.
- Strobe exclusivity: shift is never asserted together with load_shift_reg/start/clear. load_data_reg may coincide with any strobe.

## Timing
- Reset (async, rst_b=0):
  - state=IDLE, hold_full=0, div_cnt=0.
  - Outputs: tx_ready=1, tx_busy=0, tx_done=0, all strobes 0.
  - Reset in the middle of a frame abandons the frame immediately, with no tx_done.
- Accept→LOAD latency from IDLE: accept at cycle A; hold_full=1 at A+1 (IDLE); LOAD at A+2.
- Frame: LOAD at cycle L.
  - Shifts at L+k·CLKS_PER_BIT for k=1..WORD_SIZE+1.
  - tx_done at L+(WORD_SIZE+2)·CLKS_PER_BIT, which gives a full stop-bit period.
- Back-to-back: the next LOAD is at tx_done+1. Frame period = (WORD_SIZE+2)·CLKS_PER_BIT+1 cycles.
- tx_busy is high from LOAD through the tx_done cycle inclusive.
- tx_ready is low from the cycle after an accept through the LOAD cycle that consumes the byte, and high again the following cycle.

## Test plan
All scenarios run with CLKS_PER_BIT=4, WORD_SIZE=8, and a behavioural datapath model.
- Reset values: hold rst_b=0 → tx_ready=1, tx_busy=0, all strobes 0. Release reset, tx_valid=0 for 50 cycles → state stays IDLE, no strobes.
- Single byte 0xA5:
  - Accept at cycle 10 → LOAD at 12; shifts at 16,20,…,48 (9 pulses); tx_done at 52; IDLE at 53.
  - Model line sequence: 0,1,0,1,0,0,1,0,1 then 1.
- Back-to-back 0x3C then 0xFF, second offered while the first is shifting:
  - Second byte accepted 1 cycle after the first LOAD; tx_ready low until the second LOAD.
  - Second LOAD exactly 1 cycle after the first tx_done.
  - 18 shifts total, 2 tx_done pulses.
- Overrun: tx_valid held high with hold_full=1 and data changing → no load_data_reg pulse. The transmitted byte equals the originally accepted value.
- Reset mid-frame: assert rst_b=0 after the 4th shift → tx_busy=0 immediately, no tx_done. A new byte after release produces a full 9-shift frame.
- Accept on the tx_done cycle → LOAD two cycles after tx_done (via IDLE), not one.
